// File: rtl/word_packer_if.sv
// rtl/word_packer_if.sv - byte-in / word-out handshake bundle for word_packer (out_bytes under WORD_PACKER_BYTECNT_EN)
interface word_packer_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int NBYTES = BUS_WIDTH / BYTE_WIDTH;
  localparam int BCW    = $clog2(NBYTES + 1);

  // Symbol input side
  logic                  in_valid;
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;

  // Word output side
  logic                  out_valid;
  logic [BUS_WIDTH-1:0]  out_data;
  logic                  out_last;
  logic                  out_ready;
`ifdef WORD_PACKER_BYTECNT_EN
  logic [BCW-1:0]        out_bytes;
`endif

`ifdef WORD_PACKER_BYTECNT_EN
  // Environment side: produces symbols, consumes words
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_bytes
  );

  // Packer side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_bytes
  );
`else
  // Environment side: produces symbols, consumes words
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Packer side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
`endif

endinterface

// File: rtl/word_packer.sv
// rtl/word_packer.sv - little-endian byte-to-word packer with last-flush; optional out_bytes via WORD_PACKER_BYTECNT_EN
module word_packer #(
  parameter int BUS_WIDTH  = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  word_packer_if.slave bus
);

  localparam int NBYTES = BUS_WIDTH / BYTE_WIDTH;
  localparam int CW     = $clog2(NBYTES);
  localparam int BCW    = $clog2(NBYTES + 1);

  localparam logic [CW-1:0] LAST_SLOT = CW'(NBYTES - 1);

  // FILL gathers symbols, HOLD presents the closed word until it is taken.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] acc_q, acc_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 last_q, last_d;
`ifdef WORD_PACKER_BYTECNT_EN
  logic [BCW-1:0]       bytes_q, bytes_d;
`endif

  logic [BUS_WIDTH-1:0] acc_wr;
  logic                 in_ready_c;
  logic                 out_valid_c;

  // Accumulator with the incoming symbol dropped into slot cnt. Slots above
  // cnt are always zero because the accumulator is cleared on every close,
  // which gives the zero padding of a flushed partial word for free.
  always_comb begin
    acc_wr = acc_q;
    for (int k = 0; k < NBYTES; k++) begin
      if (cnt_q == CW'(k)) begin
        acc_wr[k*BYTE_WIDTH +: BYTE_WIDTH] = bus.in_data;
      end
    end
  end

  // Next-state and handshake outputs. HOLD never asserts in_ready, not even
  // in the consume cycle, so every word costs one dead input cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    data_d      = data_q;
    last_d      = last_q;
`ifdef WORD_PACKER_BYTECNT_EN
    bytes_d     = bytes_q;
`endif
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    case (state_q)
      FILL: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          if ((cnt_q == LAST_SLOT) || bus.in_last) begin
            data_d  = acc_wr;
            last_d  = bus.in_last;
`ifdef WORD_PACKER_BYTECNT_EN
            bytes_d = BCW'(cnt_q) + BCW'(1);
`endif
            cnt_d   = '0;
            acc_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d   = acc_wr;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end

      HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers; reset throws away any partial or pending word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef WORD_PACKER_BYTECNT_EN
      bytes_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef WORD_PACKER_BYTECNT_EN
      bytes_q <= bytes_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
`ifdef WORD_PACKER_BYTECNT_EN
  assign bus.out_bytes = bytes_q;
`endif

endmodule

// File: tb/tb_word_packer.sv
// tb/tb_word_packer.sv - randomized scoreboard bench for word_packer
module tb_word_packer;

  localparam int BW = 32;
  localparam int SW = 8;
  localparam int NB = BW / SW;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
    int            nbytes;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic dir_rdy  = 1'b0;
  logic rnd_rdy  = 1'b0;
  logic use_rnd  = 1'b0;

  int checks = 0;
  int errors = 0;

  word_t       exp_q[$];
  logic [SW-1:0] cur_q[$];

  logic          hold_prev = 1'b0;
  logic [BW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  word_packer_if #(.BUS_WIDTH(BW), .BYTE_WIDTH(SW)) bus ();

  word_packer #(.BUS_WIDTH(BW), .BYTE_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.out_ready = use_rnd ? rnd_rdy : dir_rdy;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: a packet is cut into NB-symbol chunks, the last chunk may be short.
  task automatic model_accept(input logic [SW-1:0] b, input logic l);
    word_t w;
    cur_q.push_back(b);
    if (cur_q.size() == NB || l) begin
      w.data = '0;
      for (int k = 0; k < cur_q.size(); k++) begin
        w.data = w.data | (BW'(cur_q[k]) << (8 * k));
      end
      w.last   = l;
      w.nbytes = cur_q.size();
      exp_q.push_back(w);
      cur_q.delete();
    end
  endtask

  // Entry and exit aligned 1 time unit after a rising edge.
  task automatic send(input logic [SW-1:0] b, input logic l, output int waits);
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = l;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        model_accept(b, l);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        break;
      end
      waits++;
      if (waits > 60) begin
        chk("send_timeout", 64'(waits), 64'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        break;
      end
    end
  endtask

  task automatic send_n(input logic [SW-1:0] b, input logic l);
    int w;
    send(b, l, w);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
`ifdef WORD_PACKER_BYTECNT_EN
    chk("rst_out_bytes", 64'(bus.out_bytes), 64'd0);
`endif
    exp_q.delete();
    cur_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 300)) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    chk("drain_partial", 64'(cur_q.size()), 64'd0);
  endtask

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      chk("ready_vs_valid", 64'(bus.in_ready), 64'(!bus.out_valid));
      if (hold_prev && bus.out_valid) begin
        chk("hold_data_stable", 64'(bus.out_data), 64'(prev_data));
        chk("hold_last_stable", 64'(bus.out_last), 64'(prev_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(bus.out_data), 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 64'(bus.out_data), 64'(e.data));
          chk("word_last", 64'(bus.out_last), 64'(e.last));
`ifdef WORD_PACKER_BYTECNT_EN
          chk("word_bytes", 64'(bus.out_bytes), 64'(e.nbytes));
`endif
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    int w;
    logic [SW-1:0] b;
    logic l;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("init_out_valid", 64'(bus.out_valid), 64'd0);
    chk("init_out_data",  64'(bus.out_data),  64'd0);
    chk("init_out_last",  64'(bus.out_last),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("init_in_ready", 64'(bus.in_ready), 64'd1);

    // 1: full word back-to-back, one cycle of out_valid, one dead input cycle
    dir_rdy = 1'b1;
    send_n(8'h11, 1'b0);
    send_n(8'h22, 1'b0);
    send_n(8'h33, 1'b0);
    send_n(8'h44, 1'b0);
    @(negedge clk);
    chk("t1_valid_rise", 64'(bus.out_valid), 64'd1);
    chk("t1_ready_low",  64'(bus.in_ready),  64'd0);
    chk("t1_data",       64'(bus.out_data),  64'h44332211);
    chk("t1_last",       64'(bus.out_last),  64'd0);
    @(negedge clk);
    chk("t1_valid_fall", 64'(bus.out_valid), 64'd0);
    chk("t1_ready_back", 64'(bus.in_ready),  64'd1);
    @(posedge clk);
    #1;

    // 2: partial word flushed by in_last
    send_n(8'hAA, 1'b0);
    send_n(8'hBB, 1'b0);
    send_n(8'hCC, 1'b1);
    @(negedge clk);
    chk("t2_data", 64'(bus.out_data), 64'h00CCBBAA);
    chk("t2_last", 64'(bus.out_last), 64'd1);
`ifdef WORD_PACKER_BYTECNT_EN
    chk("t2_bytes", 64'(bus.out_bytes), 64'd3);
`endif
    @(posedge clk);
    #1;

    // 3: downstream stall with a symbol waiting
    dir_rdy = 1'b0;
    send_n(8'h01, 1'b0);
    send_n(8'h02, 1'b0);
    send_n(8'h03, 1'b0);
    send_n(8'h04, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t3_stall_data",  64'(bus.out_data),  64'h04030201);
      chk("t3_stall_ready", 64'(bus.in_ready),  64'd0);
      chk("t3_stall_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    dir_rdy = 1'b1;
    @(negedge clk);
    chk("t3_release_no_bypass", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    send(8'h55, 1'b1, w);
    chk("t3_55_second_cycle", 64'(w), 64'd0);
    @(negedge clk);
    chk("t3_55_word", 64'(bus.out_data), 64'h00000055);
    @(posedge clk);
    #1;

    // 4: single-symbol packet
    send_n(8'h7F, 1'b1);
    @(negedge clk);
    chk("t4_data", 64'(bus.out_data), 64'h0000007F);
    chk("t4_last", 64'(bus.out_last), 64'd1);
`ifdef WORD_PACKER_BYTECNT_EN
    chk("t4_bytes", 64'(bus.out_bytes), 64'd1);
`endif
    @(posedge clk);
    #1;

    // 4b: in_last on a full word gives exactly one word
    send_n(8'hE1, 1'b0);
    send_n(8'hE2, 1'b0);
    send_n(8'hE3, 1'b0);
    send_n(8'hE4, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("t4b_no_extra_word", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // 5: reset during HOLD, then during a partial word
    dir_rdy = 1'b0;
    send_n(8'hA1, 1'b0);
    send_n(8'hA2, 1'b0);
    send_n(8'hA3, 1'b0);
    send_n(8'hA4, 1'b0);
    async_reset();
    dir_rdy = 1'b1;
    send_n(8'h01, 1'b0);
    send_n(8'h02, 1'b0);
    async_reset();
    send_n(8'h09, 1'b0);
    send_n(8'h08, 1'b0);
    send_n(8'h07, 1'b0);
    send_n(8'h06, 1'b0);
    @(negedge clk);
    chk("t5_data", 64'(bus.out_data), 64'h06070809);
    @(posedge clk);
    #1;

    // 6: random gaps and random backpressure
    use_rnd = 1'b1;
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      b = 8'($urandom_range(0, 255));
      l = (i == 63) || ($urandom_range(0, 7) == 0);
      send_n(b, l);
    end
    wait_drain();
    use_rnd = 1'b0;
    dir_rdy = 1'b1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
